// File: rtl/bnn_pkg.sv
// Shared definitions for the bnn core and its downstream stages.
// Holds default sizing and the class index type used by the classification stage.
package bnn_pkg;

  localparam int NUM_CLASSES_DEFAULT = 10;
  localparam int COUNT_WIDTH_DEFAULT = 16;
  localparam int CLASS_WIDTH_DEFAULT = $clog2(NUM_CLASSES_DEFAULT);

  typedef logic [CLASS_WIDTH_DEFAULT-1:0] class_idx_t;
  typedef logic [COUNT_WIDTH_DEFAULT-1:0] count_t;

endpackage

// File: rtl/bnn_argmax_if.sv
// Stream interface between the bnn core popcount output and the argmax stage,
// plus the argmax result channel towards the consumer.
interface bnn_argmax_if
  import bnn_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_CLASSES_DEFAULT,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT
);

  localparam int CLASS_WIDTH = $clog2(NUM_CLASSES);

  logic [COUNT_WIDTH-1:0] count_in;
  logic                   count_in_valid;
  logic                   in_ready;
  logic [CLASS_WIDTH-1:0] class_out;
  logic [COUNT_WIDTH-1:0] class_count_out;
  logic                   class_out_valid;
  logic                   class_out_ready;
  logic                   overflow;

  // master: the environment (core + result consumer); slave: the argmax stage
  modport master (
    output count_in,
    output count_in_valid,
    input  in_ready,
    input  class_out,
    input  class_count_out,
    input  class_out_valid,
    output class_out_ready,
    input  overflow
  );

  modport slave (
    input  count_in,
    input  count_in_valid,
    output in_ready,
    output class_out,
    output class_count_out,
    output class_out_valid,
    input  class_out_ready,
    output overflow
  );

endinterface

// File: rtl/bnn_result_reg.sv
// One-entry valid/ready holding register; a load in the same cycle as a drain
// keeps valid high and replaces the payload.
module bnn_result_reg #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [PAYLOAD_W-1:0] load_data,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_data
);

  logic                 vld_p1;
  logic [PAYLOAD_W-1:0] data_p1;

  // Stage p1: held result
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= load_data;
    end else if (vld_p1 && out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;

endmodule

// File: rtl/bnn_argmax.sv
// Streaming argmax over the final-layer popcounts of the bnn core: one class
// per beat, winning class index and count emitted once per image.
module bnn_argmax
  import bnn_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_CLASSES_DEFAULT,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT
) (
  input logic        clk,
  input logic        rst,
  bnn_argmax_if.slave bus
);

  localparam int CLASS_WIDTH = $clog2(NUM_CLASSES);
  localparam int PAYLOAD_W   = CLASS_WIDTH + COUNT_WIDTH;
  localparam logic [CLASS_WIDTH-1:0] LAST_IDX = CLASS_WIDTH'(NUM_CLASSES - 1);

  // Strict compare so ties keep the earlier (lower) class index.
  function automatic logic beats_best(input logic                   first,
                                      input logic [COUNT_WIDTH-1:0] cand,
                                      input logic [COUNT_WIDTH-1:0] best);
    return first || (cand > best);
  endfunction

  logic [CLASS_WIDTH-1:0] idx_p0;
  logic [COUNT_WIDTH-1:0] best_val_p0;
  logic [CLASS_WIDTH-1:0] best_idx_p0;
  logic                   overflow_p0;

  logic                   in_ready;
  logic                   accept;
  logic                   last_beat;
  logic                   take;
  logic [COUNT_WIDTH-1:0] nxt_val;
  logic [CLASS_WIDTH-1:0] nxt_idx;

  logic                   res_vld_p1;
  logic [PAYLOAD_W-1:0]   res_data_p1;

  assign last_beat = (idx_p0 == LAST_IDX);
  // Only the closing beat of an image needs a free result slot.
  assign in_ready  = !res_vld_p1 || bus.class_out_ready || !last_beat;
  assign accept    = bus.count_in_valid && in_ready;
  assign take      = beats_best(idx_p0 == '0, bus.count_in, best_val_p0);
  assign nxt_val   = take ? bus.count_in : best_val_p0;
  assign nxt_idx   = take ? idx_p0 : best_idx_p0;

  // Stage p0: class counter, running maximum, sticky drop flag
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_p0      <= '0;
      best_val_p0 <= '0;
      best_idx_p0 <= '0;
      overflow_p0 <= 1'b0;
    end else begin
      if (accept) begin
        idx_p0      <= last_beat ? '0 : idx_p0 + CLASS_WIDTH'(1);
        best_val_p0 <= nxt_val;
        best_idx_p0 <= nxt_idx;
      end
      if (bus.count_in_valid && !in_ready) begin
        overflow_p0 <= 1'b1;
      end
    end
  end

  // Stage p1: result holding register, loaded with the comparison that
  // already includes the final beat
  bnn_result_reg #(
    .PAYLOAD_W (PAYLOAD_W)
  ) u_result (
    .clk       (clk),
    .rst       (rst),
    .load      (accept && last_beat),
    .load_data ({nxt_idx, nxt_val}),
    .out_ready (bus.class_out_ready),
    .out_valid (res_vld_p1),
    .out_data  (res_data_p1)
  );

  assign bus.in_ready        = in_ready;
  assign bus.class_out_valid = res_vld_p1;
  assign bus.class_out       = res_data_p1[PAYLOAD_W-1:COUNT_WIDTH];
  assign bus.class_count_out = res_data_p1[COUNT_WIDTH-1:0];
  assign bus.overflow        = overflow_p0;

endmodule

// File: doc/bnn_argmax.md
# bnn_argmax

Streaming classification stage that sits directly downstream of the `bnn` core. It consumes the per-neuron popcount values of the final layer (`count_out`/`data_out_valid`), one class per beat, and tracks the running maximum. Once all `NUM_CLASSES` counts for an image have arrived, it emits the winning class index and its count on a valid/ready output. It back-pressures the core through `in_ready`, which drives the core's `ready` input, so back-to-back images stream without loss.

## Interface
- `NUM_CLASSES`, default 10: output-layer neurons (classes) per image; must be ≥ 2.
- `COUNT_WIDTH`, default 16: width of each incoming popcount; unsigned.
- `CLASS_WIDTH`, derived localparam: `$clog2(NUM_CLASSES)`; not overridable.

- `clk`  in  1  clock; every flop is clocked on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `count_in`  in  COUNT_WIDTH  popcount for class `idx`; driven from the core's `count_out`.
- `count_in_valid`  in  1  beat present; driven from the core's `data_out_valid`.
- `in_ready`  out  1  beat acceptance; drives the core's `ready`.
- `class_out`  out  CLASS_WIDTH  winning class index.
- `class_count_out`  out  COUNT_WIDTH  count of the winning class.
- `class_out_valid`  out  1  result held and waiting for the consumer.
- `class_out_ready`  in  1  consumer accepts the result.
- `overflow`  out  1  sticky error flag: a beat arrived while `in_ready` was 0.

## Operation
- A beat is accepted when `count_in_valid && in_ready`. Beats arrive in class order 0..NUM_CLASSES-1.
- Class counter `idx` (0..NUM_CLASSES-1) advances by one per accepted beat and wraps to 0 after NUM_CLASSES-1.
- Running registers `best_val` and `best_idx`:
  - `idx==0`: load unconditionally.
  - Otherwise: load only if `count_in > best_val` (strict). Ties go to the lowest index.
- On acceptance at `idx==NUM_CLASSES-1`:
  - the final comparison, including the current beat, is written to `class_out`/`class_count_out`;
  - `class_out_valid` is set;
  - `idx` returns to 0.
- Output register: `class_out_valid` clears on `class_out_valid && class_out_ready`, unless a new result loads in the same cycle, in which case it stays 1 and carries the new data.
- `in_ready = !class_out_valid || class_out_ready || (idx != NUM_CLASSES-1)`. Only the final beat of an image stalls, and only while the previous result is unconsumed. This is a combinational path from `class_out_ready` to `in_ready`.
- A beat with `count_in_valid && !in_ready`:
  - the beat is dropped;
  - `idx` and the best registers are unchanged;
  - `overflow` is set and stays set until `rst`.
- All arithmetic is unsigned, COUNT_WIDTH wide, compare only; there is no saturation.

## Timing
- Reset values: `class_out`=0, `class_count_out`=0, `class_out_valid`=0, `overflow`=0, `idx`=0, `best_val`=0, `best_idx`=0. Because `class_out_valid`=0 in reset, `in_ready` reads 1 during and after reset.
- Latency: `class_out_valid` rises on the first clock edge after the final beat is accepted (1 cycle).
- Throughput: one beat per cycle sustained. With `class_out_ready` held high, one result per NUM_CLASSES cycles and no bubbles.
- `class_out`/`class_count_out` stay stable while `class_out_valid && !class_out_ready`.
- Reset mid-image or mid-hold: the partial image is discarded and any pending result is lost. The next accepted beat is class 0.
- `count_in` is ignored whenever `count_in_valid`=0.

## Structure
- The shared `bnn_pkg` holds `COUNT_WIDTH` default, `NUM_CLASSES` default, and a `class_idx_t` typedef sized `$clog2(NUM_CLASSES)`. The block imports these.
- One sub-module, `bnn_result_reg`: a 1-entry valid/ready holding register parameterised by payload width, carrying `{class, count}`. The rest (counter, comparator, ready logic) is flat in `bnn_argmax`.

## Test plan
1. NUM_CLASSES=4, counts 3,9,5,7 back-to-back with `class_out_ready`=1 → `class_out`=1 and `class_count_out`=9, one cycle after beat 3; `in_ready` stays 1 throughout.
2. Ties: counts 6,6,2,6 → `class_out`=0, `class_count_out`=6.
3. Back-pressure: hold `class_out_ready`=0 and send two images (1,2,3,4 then 8,0,0,0):
   - `in_ready` drops to 0 only at the final beat of image 2; result 3/4 is held stable.
   - Raise `class_out_ready` → 3/4 is accepted and `in_ready` rises the same cycle.
   - Next cycle → 0/8 is valid; `overflow` stays 0.
4. Overflow: repeat scenario 3 but force `count_in_valid`=1 while `in_ready`=0 → `overflow`=1 sticky. The held result is unchanged. The next accepted beat completes image 2 with its original data.
5. Reset mid-image: accept 2 of 4 beats, assert `rst` for 1 cycle, then send 0,0,5,1 → `class_out`=2; no stale result appears.
6. Extremes with COUNT_WIDTH=16: counts 16'hFFFF,0,16'hFFFF,16'hFFFE → `class_out`=0 and `class_count_out`=16'hFFFF.
